serial_mag_comp: RTL and testbench

- Parametrised, sequential successor to the team's fixed 2-bit combinational comparator.
- Latches two WIDTH-bit operands on a start handshake and compares them MSB-first, STEP bits per cycle.
- Terminates early at the first differing digit and reports one-hot lt/eq/gt with a done pulse and the number of compare cycles used.
- Intended for the datapath library as a low-area comparator where latency is acceptable.

---
 rtl/serial_mag_comp.sv | 127 ++++++++++++
 tb/tb_serial_mag_comp.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/serial_mag_comp.sv
// rtl/serial_mag_comp.sv - MSB-first serial magnitude comparator, STEP bits per cycle with early exit.
// Optional signed compare (sgn port) when SERIAL_CMP_SIGNED_EN is defined.
module serial_mag_comp #(
    parameter int WIDTH = 8,
    parameter int STEP  = 1,
    localparam int NDIG = WIDTH / STEP,
    localparam int CW   = $clog2(NDIG) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
`ifdef SERIAL_CMP_SIGNED_EN
    input  logic             sgn,
`endif
    output logic             busy,
    output logic             done,
    output logic             lt,
    output logic             eq,
    output logic             gt,
    output logic [CW-1:0]    cyc
);

    localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_HOLD} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [CW-1:0]    cyc_q, cyc_d;
    logic             lt_q, lt_d, eq_q, eq_d, gt_q, gt_d, done_q, done_d;
    logic [WIDTH-1:0] a_in, b_in;
    logic [STEP-1:0]  dig_a, dig_b;

`ifdef SERIAL_CMP_SIGNED_EN
    // Flipping the sign bit maps two's complement onto offset binary,
    // so the unsigned digit compare below yields the signed ordering.
    localparam logic [WIDTH-1:0] MSB_MASK = WIDTH'(1) << (WIDTH - 1);
    assign a_in = A ^ (sgn ? MSB_MASK : '0);
    assign b_in = B ^ (sgn ? MSB_MASK : '0);
`else
    assign a_in = A;
    assign b_in = B;
`endif

    assign dig_a = a_q[idx_q*STEP +: STEP];
    assign dig_b = b_q[idx_q*STEP +: STEP];

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        idx_d   = idx_q;
        cyc_d   = cyc_q;
        lt_d    = lt_q;
        eq_d    = eq_q;
        gt_d    = gt_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE, S_HOLD: begin
                if (start) begin
                    state_d = S_RUN;
                    a_d     = a_in;
                    b_d     = b_in;
                    idx_d   = IW'(NDIG - 1);
                    cyc_d   = '0;
                    lt_d    = 1'b0;
                    eq_d    = 1'b0;
                    gt_d    = 1'b0;
                end
            end
            S_RUN: begin
                cyc_d = cyc_q + CW'(1);
                if (dig_a > dig_b) begin
                    gt_d    = 1'b1;
                    done_d  = 1'b1;
                    state_d = S_HOLD;
                end else if (dig_a < dig_b) begin
                    lt_d    = 1'b1;
                    done_d  = 1'b1;
                    state_d = S_HOLD;
                end else if (idx_q == '0) begin
                    eq_d    = 1'b1;
                    done_d  = 1'b1;
                    state_d = S_HOLD;
                end else begin
                    idx_d = idx_q - IW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            idx_q   <= '0;
            cyc_q   <= '0;
            lt_q    <= 1'b0;
            eq_q    <= 1'b0;
            gt_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            idx_q   <= idx_d;
            cyc_q   <= cyc_d;
            lt_q    <= lt_d;
            eq_q    <= eq_d;
            gt_q    <= gt_d;
            done_q  <= done_d;
        end
    end

    assign busy = (state_q == S_RUN);
    assign done = done_q;
    assign lt   = lt_q;
    assign eq   = eq_q;
    assign gt   = gt_q;
    assign cyc  = cyc_q;

endmodule

// File: tb/tb_serial_mag_comp.sv
// tb/tb_serial_mag_comp.sv - directed self-checking bench for serial_mag_comp (8/1 and 4/2 builds).
module tb_serial_mag_comp;

    logic       clk = 1'b0;
    logic       rst, start, start4, sgn;
    logic [7:0] a, b;
    logic [3:0] a4, b4;
    logic       busy, done, lt, eq, gt;
    logic [3:0] cyc;
    logic       busy4, done4, lt4, eq4, gt4;
    logic [1:0] cyc4;
    int         total = 0;
    int         bad   = 0;
    int         n;
    bit         seen;

    always #5 clk = ~clk;

    serial_mag_comp #(.WIDTH(8), .STEP(1)) u_dut (
        .clk(clk), .rst(rst), .start(start), .A(a), .B(b),
`ifdef SERIAL_CMP_SIGNED_EN
        .sgn(sgn),
`endif
        .busy(busy), .done(done), .lt(lt), .eq(eq), .gt(gt), .cyc(cyc)
    );

    serial_mag_comp #(.WIDTH(4), .STEP(2)) u_dut4 (
        .clk(clk), .rst(rst), .start(start4), .A(a4), .B(b4),
`ifdef SERIAL_CMP_SIGNED_EN
        .sgn(1'b0),
`endif
        .busy(busy4), .done(done4), .lt(lt4), .eq(eq4), .gt(gt4), .cyc(cyc4)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_done(output int cycles, output bit got);
        cycles = 0;
        for (int i = 0; i < 20 && !done; i++) begin
            tick();
            cycles++;
        end
        got = done;
    endtask

    task automatic run8(input logic [7:0] va, input logic [7:0] vb, output int cycles, output bit got);
        a = va; b = vb; start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(cycles, got);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; start4 = 1'b0; sgn = 1'b0;
        a = '0; b = '0; a4 = '0; b4 = '0;
        tick(); tick();
        rst = 1'b0;
        repeat (5) tick();
        chk("reset_flags", {busy, done, lt, eq, gt}, 5'b0);
        chk("reset_cyc", cyc, 0);

        // MSB differs: decided on the first RUN edge
        run8(8'h80, 8'h7F, n, seen);
        chk("msb_done", seen, 1);
        chk("msb_latency", n, 1);
        chk("msb_flags", {busy, lt, eq, gt}, 4'b0001);
        chk("msb_cyc", cyc, 1);
        tick();
        chk("msb_done_pulse", done, 0);
        chk("msb_hold_gt", {lt, eq, gt}, 3'b001);

        run8(8'hA5, 8'hA5, n, seen);
        chk("eq_done", seen, 1);
        chk("eq_latency", n, 8);
        chk("eq_flags", {lt, eq, gt}, 3'b010);
        chk("eq_cyc", cyc, 8);

        // start mid-RUN must be ignored, then back-to-back start in the done cycle
        a = 8'h10; b = 8'h11; start = 1'b1;
        tick();
        start = 1'b0;
        chk("b2b_busy", busy, 1);
        tick(); tick();
        a = 8'hFF; start = 1'b1;
        tick();
        start = 1'b0; a = 8'h00;
        wait_done(n, seen);
        chk("b2b_first_done", seen, 1);
        chk("b2b_first_flags", {lt, eq, gt}, 3'b100);
        chk("b2b_first_cyc", cyc, 8);
        a = 8'h03; b = 8'h02; start = 1'b1;
        tick();
        start = 1'b0; a = 8'hFF; b = 8'hFF;
        chk("b2b_accept_clear", {busy, done, lt, eq, gt}, 5'b10000);
        chk("b2b_accept_cyc", cyc, 0);
        wait_done(n, seen);
        chk("b2b_second_done", seen, 1);
        chk("b2b_second_latency", n, 8);
        chk("b2b_second_flags", {lt, eq, gt}, 3'b001);
        chk("b2b_second_cyc", cyc, 8);

        // reset during RUN aborts without a done pulse
        a = 8'h00; b = 8'h01; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        chk("abort_busy_before", busy, 1);
        rst = 1'b1;
        tick();
        chk("abort_flags", {busy, done, lt, eq, gt}, 5'b0);
        chk("abort_cyc", cyc, 0);
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (done || busy) seen = 1'b1;
        end
        chk("abort_no_done", seen, 0);
        run8(8'h5A, 8'h5A, n, seen);
        chk("after_abort_done", seen, 1);
        chk("after_abort_flags", {lt, eq, gt, cyc}, {3'b010, 4'd8});

`ifdef SERIAL_CMP_SIGNED_EN
        sgn = 1'b1;
        run8(8'hFF, 8'h01, n, seen);
        chk("signed_flags", {lt, eq, gt}, 3'b100);
        chk("signed_cyc", cyc, 1);
        sgn = 1'b0;
        run8(8'hFF, 8'h01, n, seen);
        chk("unsigned_flags", {lt, eq, gt}, 3'b001);
        chk("unsigned_cyc", cyc, 1);
`endif

        // exhaustive 4-bit sweep, two 2-bit digits
        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 16; j++) begin
                logic [2:0] ef;
                logic [1:0] ec;
                a4 = 4'(i); b4 = 4'(j); start4 = 1'b1;
                tick();
                start4 = 1'b0;
                for (int k = 0; k < 10 && !done4; k++) tick();
                ef = (i < j) ? 3'b100 : (i == j) ? 3'b010 : 3'b001;
                ec = ((i / 4) == (j / 4)) ? 2'd2 : 2'd1;
                chk($sformatf("sweep_%0d_%0d", i, j), {done4, lt4, eq4, gt4, cyc4}, {1'b1, ef, ec});
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
